axi_trace_slave_responder: RTL and testbench
============================================

// Module: axi_trace_slave_responder
// PURPOSE
// - AXI4 slave-side responder that terminates the master-side trace interface in hw-emulation replay.
// - Accepts AW/W and AR bursts, backs them with an internal word memory, and returns B/R responses.
// - Lets replayed master traces run without the real downstream memory subsystem.
// - Write and read paths are independent and run concurrently.
// PARAMETERS
// - ADDRW     32   byte address width
// - DATAW     32   data width; power of 2, >=8
// - LENGTHW   4    AxLEN width; a burst is AxLEN+1 beats
// - SIZEW     3    AxSIZE width
// - IDW       1    ID width
// - MEM_WORDS 256  memory depth in DATAW words; power of 2
// PORTS
// - clk    in 1  single clock domain
// - rst    in 1  asynchronous reset, active-low
// - AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  IDW/ADDRW/LENGTHW/SIZEW/2  write address
// - AWVALID in 1; AWREADY out 1  write address handshake
// - WDATA/WSTRB/WLAST  in  DATAW/DATAW/8/1  write data
// - WVALID in 1; WREADY out 1  write data handshake
// - BID out IDW; BRESP out 2; BVALID out 1; BREADY in 1  write response
// - ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  IDW/ADDRW/LENGTHW/SIZEW/2  read address
// - ARVALID in 1; ARREADY out 1  read address handshake
// - RID out IDW; RDATA out DATAW; RRESP out 2; RLAST out 1; RVALID out 1; RREADY in 1  read data
// BEHAVIOUR
// - Reset (rst=0, asynchronous): all FSMs go to IDLE; every READY/VALID output 0; BID/BRESP/RID/RDATA/RRESP/RLAST 0.
//   Memory contents are not reset. Reset mid-burst abandons the burst; no B or R beat is issued.
// - READY outputs are registered. AWREADY and ARREADY rise in the first clk edge after rst deasserts.
// - Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
//   - W_IDLE: AWREADY=1. On AW handshake, latch ID/addr/len/size/burst, clear the error flag, go to W_DATA. AWREADY=0 from the next cycle.
//   - W_DATA: WREADY=1. Accepts one beat per cycle. Each byte lane with WSTRB[i]=1 is written to mem[addr>>log2(DATAW/8)].
//     The beat counter decides the last beat; WLAST is only checked. WLAST asserted early or missing on the final beat sets the error flag.
//   - After the final-beat handshake: WREADY=0, BVALID=1 on the next cycle, state W_RESP.
//   - W_RESP: hold BID/BRESP until BREADY. Then BVALID=0, AWREADY=1 on the next cycle.
// - Read FSM R_IDLE -> R_DATA -> R_IDLE:
//   - R_IDLE: ARREADY=1. On AR handshake, latch the request; RDATA register loads mem[beat0]; RVALID=1 on the next cycle.
//   - R_DATA: RDATA/RRESP/RLAST stay stable while RVALID=1 and RREADY=0.
//   - On an R handshake that is not the last beat, load the next beat in the same edge. Full throughput is one beat per cycle.
//   - RLAST=1 only on beat AxLEN. After the last handshake, RVALID=0 and ARREADY=1 on the next cycle.
// - Address generation (per beat, step = 1<<AxSIZE):
//   - FIXED (0): address constant.
//   - INCR (1): addr += step. Wraps modulo 2^ADDRW.
//   - WRAP (2): wraps within an aligned window of (len+1)*step. Legal only for len in {1,3,7,15} with an aligned start address.
//     Otherwise treated as INCR and the burst is flagged.
//   - Reserved (3): treated as INCR and flagged.
// - Error rules: BRESP/RRESP = SLVERR (2'b10) for any of the following; otherwise OKAY (2'b00).
//   - AxSIZE > log2(DATAW/8)
//   - illegal burst
//   - a beat word index >= MEM_WORDS
//   - write WLAST mismatch
//   Out-of-range beats do not write and return RDATA=0. Read error is per beat; write error is sticky for the burst.
//   Narrow reads return the full word.
// - Simultaneous events:
//   - A write beat and a read load to the same word in one cycle: the read returns the old data (read-first).
//   - AW and AR accepted in the same cycle: both proceed independently.
//   - No outstanding-transaction queueing: one write and one read in flight at most.
// STRUCTURE
// - axi_trace_pkg:
//   - burst_e {FIXED,INCR,WRAP,RSVD}
//   - RESP_OKAY/RESP_SLVERR constants
//   - wstate_e {W_IDLE,W_DATA,W_RESP}, rstate_e {R_IDLE,R_DATA}
// - Sub-module axi_trace_burst_addr_gen (combinational):
//   - inputs: current addr, start addr, len, size, burst
//   - outputs: next addr, illegal flag
//   - one instance each in the write and read paths
// - Memory: 1 write port + 1 read port register array, DATAW/8 byte enables.
// TESTING
// - Reset: hold rst=0 for 3 cycles with AWVALID=1 -> all READY/VALID 0; AWREADY=ARREADY=1 one edge after release.
// - INCR write: AW addr 0x10, len 3, size 2, then WDATA 0xA0..0xA3, WSTRB 0xF -> BVALID 1 cycle after the 4th beat, BRESP=0.
//   Then AR of the same burst -> RDATA A0..A3, RLAST on beat 3, RRESP=0.
// - Backpressure: RREADY toggles 1/0 during a len-7 read -> RDATA stable while stalled; exactly 8 beats; BREADY held 0 for 5 cycles keeps BVALID/BID stable.
// - WRAP: write 0x1..0x4 to words 0..3, then AR addr 0x08, len 3, size 2, burst WRAP -> RDATA 0x3,0x4,0x1,0x2.
//   WRAP with len 2 -> RRESP=SLVERR on every beat.
// - Errors:
//   - AW with WLAST on beat 1 of len 3 -> BRESP=2'b10.
//   - AR at word MEM_WORDS -> RDATA 0, RRESP=2'b10.
//   - ARSIZE=3 with DATAW 32 -> SLVERR.
// - Concurrency: a write of 0xBEEF to word 5 coincides with the read of word 5 (old 0x1234) -> read returns 0x1234; a subsequent read returns 0xBEEF.

Source files
------------

// File: rtl/axi_trace_pkg.sv
// Shared types and constants for the AXI trace slave responder.
package axi_trace_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2,
        RSVD  = 2'd3
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

endpackage

// File: rtl/axi_trace_slave_responder_if.sv
// AXI4 bus bundle between a replayed master trace and the slave responder.
interface axi_trace_slave_responder_if #(
    parameter int unsigned ADDRW   = 32,
    parameter int unsigned DATAW   = 32,
    parameter int unsigned LENGTHW = 4,
    parameter int unsigned SIZEW   = 3,
    parameter int unsigned IDW     = 1
);
    logic [IDW-1:0]     awid;
    logic [ADDRW-1:0]   awaddr;
    logic [LENGTHW-1:0] awlen;
    logic [SIZEW-1:0]   awsize;
    logic [1:0]         awburst;
    logic               awvalid;
    logic               awready;
    logic [DATAW-1:0]   wdata;
    logic [DATAW/8-1:0] wstrb;
    logic               wlast;
    logic               wvalid;
    logic               wready;
    logic [IDW-1:0]     bid;
    logic [1:0]         bresp;
    logic               bvalid;
    logic               bready;
    logic [IDW-1:0]     arid;
    logic [ADDRW-1:0]   araddr;
    logic [LENGTHW-1:0] arlen;
    logic [SIZEW-1:0]   arsize;
    logic [1:0]         arburst;
    logic               arvalid;
    logic               arready;
    logic [IDW-1:0]     rid;
    logic [DATAW-1:0]   rdata;
    logic [1:0]         rresp;
    logic               rlast;
    logic               rvalid;
    logic               rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awready, wready, bid, bresp, bvalid,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_trace_burst_addr_gen.sv
// Per-beat AXI address stepping (FIXED/INCR/WRAP) with burst legality check.
module axi_trace_burst_addr_gen
    import axi_trace_pkg::*;
#(
    parameter int unsigned ADDRW   = 32,
    parameter int unsigned LENGTHW = 4,
    parameter int unsigned SIZEW   = 3
) (
    input  logic [ADDRW-1:0]   cur_addr,
    input  logic [ADDRW-1:0]   start_addr,
    input  logic [LENGTHW-1:0] len,
    input  logic [SIZEW-1:0]   size,
    input  logic [1:0]         burst,
    output logic [ADDRW-1:0]   next_addr_c,
    output logic               illegal_c
);
    logic [ADDRW-1:0] step;
    logic [ADDRW-1:0] win_mask;
    logic [ADDRW-1:0] incr_addr;
    logic             wrap_ok;

    // Next beat address; WRAP needs len+1 a power of two >= 2 and a size-aligned start.
    always_comb begin
        step        = ADDRW'(1) << size;
        win_mask    = ((ADDRW'(len) + ADDRW'(1)) << size) - ADDRW'(1);
        incr_addr   = cur_addr + step;
        wrap_ok     = (len != '0) && ((len & (len + LENGTHW'(1))) == '0)
                      && ((start_addr & (step - ADDRW'(1))) == '0);
        next_addr_c = incr_addr;
        illegal_c   = 1'b0;
        case (burst_e'(burst))
            FIXED: next_addr_c = cur_addr;
            INCR:  next_addr_c = incr_addr;
            WRAP: begin
                if (wrap_ok) next_addr_c = (cur_addr & ~win_mask) | (incr_addr & win_mask);
                else         illegal_c   = 1'b1;
            end
            default: illegal_c = 1'b1;
        endcase
    end
endmodule

// File: rtl/axi_trace_slave_responder.sv
// AXI4 slave responder backed by a word memory; independent write and read FSMs.
module axi_trace_slave_responder
    import axi_trace_pkg::*;
#(
    parameter int unsigned ADDRW     = 32,
    parameter int unsigned DATAW     = 32,
    parameter int unsigned LENGTHW   = 4,
    parameter int unsigned SIZEW     = 3,
    parameter int unsigned IDW       = 1,
    parameter int unsigned MEM_WORDS = 256
) (
    input logic                        clk,
    input logic                        rst,
    axi_trace_slave_responder_if.slave bus
);
    localparam int unsigned STRBW = DATAW / 8;
    localparam int unsigned OFFW  = $clog2(STRBW);
    localparam int unsigned IDXW  = $clog2(MEM_WORDS);

    logic [DATAW-1:0] mem [MEM_WORDS];

    function automatic logic oob(input logic [ADDRW-1:0] a);
        return (a >> OFFW) >= ADDRW'(MEM_WORDS);
    endfunction

    function automatic logic [IDXW-1:0] widx(input logic [ADDRW-1:0] a);
        return IDXW'(a >> OFFW);
    endfunction

    // ---------------- write path ----------------
    wstate_e            wstate_q, wstate_d;
    logic               awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic               w_err_q, w_err_d;
    logic [1:0]         bresp_q, bresp_d;
    logic [IDW-1:0]     bid_q, bid_d, w_id_q;
    logic [ADDRW-1:0]   w_addr_q, w_start_q, w_next;
    logic [LENGTHW-1:0] w_len_q, w_cnt_q;
    logic [SIZEW-1:0]   w_size_q;
    logic [1:0]         w_burst_q;
    logic               aw_hs, w_hs, w_illegal, w_last_beat, w_beat_err;

    assign aw_hs       = bus.awvalid && awready_q;
    assign w_hs        = bus.wvalid && wready_q;
    assign w_last_beat = (w_cnt_q == w_len_q);
    assign w_beat_err  = w_illegal || (w_size_q > SIZEW'(OFFW)) || oob(w_addr_q)
                         || (bus.wlast != w_last_beat);

    axi_trace_burst_addr_gen #(.ADDRW(ADDRW), .LENGTHW(LENGTHW), .SIZEW(SIZEW)) u_w_gen (
        .cur_addr(w_addr_q), .start_addr(w_start_q), .len(w_len_q), .size(w_size_q),
        .burst(w_burst_q), .next_addr_c(w_next), .illegal_c(w_illegal)
    );

    // Write FSM next state and registered handshake/response outputs.
    always_comb begin
        wstate_d  = wstate_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        bid_d     = bid_q;
        w_err_d   = w_err_q;
        case (wstate_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (aw_hs) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_err_d   = 1'b0;
                    wstate_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    w_err_d = w_err_q || w_beat_err;
                    if (w_last_beat) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bid_d    = w_id_q;
                        bresp_d  = (w_err_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                        wstate_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Write FSM state and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
            w_err_q   <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            w_err_q   <= w_err_d;
        end
    end

    // Write burst context: latched on AW, stepped on each accepted beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_start_q <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_cnt_q   <= '0;
        end else if (aw_hs) begin
            w_id_q    <= bus.awid;
            w_addr_q  <= bus.awaddr;
            w_start_q <= bus.awaddr;
            w_len_q   <= bus.awlen;
            w_size_q  <= bus.awsize;
            w_burst_q <= bus.awburst;
            w_cnt_q   <= '0;
        end else if (w_hs) begin
            w_addr_q  <= w_next;
            w_cnt_q   <= w_cnt_q + LENGTHW'(1);
        end
    end

    // Byte-lane memory write; out-of-range beats are dropped.
    always_ff @(posedge clk) begin
        if (w_hs && !oob(w_addr_q)) begin
            for (int i = 0; i < STRBW; i++) begin
                if (bus.wstrb[i]) mem[widx(w_addr_q)][i*8 +: 8] <= bus.wdata[i*8 +: 8];
            end
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.bid     = bid_q;

    // ---------------- read path ----------------
    rstate_e            rstate_q, rstate_d;
    logic               arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [IDW-1:0]     rid_q, rid_d;
    logic [DATAW-1:0]   rdata_q, rdata_d, r_beat_data;
    logic [1:0]         rresp_q, rresp_d;
    logic [ADDRW-1:0]   r_addr_q, r_start_q, r_next, rg_cur, rg_start, r_load_addr;
    logic [LENGTHW-1:0] r_len_q, r_cnt_q, rg_len;
    logic [SIZEW-1:0]   r_size_q, rg_size;
    logic [1:0]         r_burst_q, rg_burst;
    logic               r_idle, ar_hs, r_hs, r_illegal, r_beat_err;

    // In idle the generator sees the incoming AR so beat 0 can be judged before latching.
    assign r_idle      = (rstate_q == R_IDLE);
    assign rg_cur      = r_idle ? bus.araddr  : r_addr_q;
    assign rg_start    = r_idle ? bus.araddr  : r_start_q;
    assign rg_len      = r_idle ? bus.arlen   : r_len_q;
    assign rg_size     = r_idle ? bus.arsize  : r_size_q;
    assign rg_burst    = r_idle ? bus.arburst : r_burst_q;
    assign r_load_addr = r_idle ? bus.araddr  : r_next;
    assign ar_hs       = bus.arvalid && arready_q;
    assign r_hs        = rvalid_q && bus.rready;
    assign r_beat_err  = r_illegal || (rg_size > SIZEW'(OFFW)) || oob(r_load_addr);
    assign r_beat_data = oob(r_load_addr) ? '0 : mem[widx(r_load_addr)];

    axi_trace_burst_addr_gen #(.ADDRW(ADDRW), .LENGTHW(LENGTHW), .SIZEW(SIZEW)) u_r_gen (
        .cur_addr(rg_cur), .start_addr(rg_start), .len(rg_len), .size(rg_size),
        .burst(rg_burst), .next_addr_c(r_next), .illegal_c(r_illegal)
    );

    // Read FSM next state; beat data is loaded on AR accept and on each non-final R handshake.
    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rid_d     = bus.arid;
                    rdata_d   = r_beat_data;
                    rresp_d   = r_beat_err ? RESP_SLVERR : RESP_OKAY;
                    rlast_d   = (bus.arlen == '0);
                    rstate_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        arready_d = 1'b1;
                        rstate_d  = R_IDLE;
                    end else begin
                        rdata_d = r_beat_data;
                        rresp_d = r_beat_err ? RESP_SLVERR : RESP_OKAY;
                        rlast_d = ((r_cnt_q + LENGTHW'(1)) == r_len_q);
                    end
                end
            end
        endcase
    end

    // Read FSM state and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
        end
    end

    // Read burst context: latched on AR, stepped on each non-final R handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr_q  <= '0;
            r_start_q <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_cnt_q   <= '0;
        end else if (ar_hs) begin
            r_addr_q  <= bus.araddr;
            r_start_q <= bus.araddr;
            r_len_q   <= bus.arlen;
            r_size_q  <= bus.arsize;
            r_burst_q <= bus.arburst;
            r_cnt_q   <= '0;
        end else if (r_hs && !rlast_q) begin
            r_addr_q  <= r_next;
            r_cnt_q   <= r_cnt_q + LENGTHW'(1);
        end
    end

    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rlast   = rlast_q;
    assign bus.rid     = rid_q;
endmodule

// File: tb/tb_axi_trace_slave_responder.sv
// Bench for axi_trace_slave_responder: directed table, corner sequences, random traffic vs model.
module tb_axi_trace_slave_responder;
    import axi_trace_pkg::*;

    localparam int unsigned ADDRW     = 32;
    localparam int unsigned DATAW     = 32;
    localparam int unsigned LENGTHW   = 4;
    localparam int unsigned SIZEW     = 3;
    localparam int unsigned IDW       = 1;
    localparam int unsigned MEM_WORDS = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi_trace_slave_responder_if #(.ADDRW(ADDRW), .DATAW(DATAW), .LENGTHW(LENGTHW),
                                   .SIZEW(SIZEW), .IDW(IDW)) bus ();

    axi_trace_slave_responder #(.ADDRW(ADDRW), .DATAW(DATAW), .LENGTHW(LENGTHW), .SIZEW(SIZEW),
                                .IDW(IDW), .MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model [MEM_WORDS];

    typedef struct {
        bit          is_rd;
        logic [31:0] addr;
        int          len;
        int          size;
        int          burst;
        int          early;
        logic [1:0]  exp_resp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rules written directly from the burst definitions.
    function automatic bit wrap_legal(input logic [31:0] start, input int len, input int size);
        longint step = longint'(1) << size;
        return (len inside {1, 3, 7, 15}) && ((longint'(start) % step) == 0);
    endfunction

    function automatic bit burst_bad(input logic [31:0] start, input int len, input int size,
                                     input int burst);
        return (size > 2) || (burst == 3) || (burst == 2 && !wrap_legal(start, len, size));
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input int size, input int burst, input int k);
        longint step = longint'(1) << size;
        longint win  = longint'(len + 1) * step;
        longint s    = longint'(start);
        longint base;
        if (burst == 0) return start;
        if (burst == 2 && wrap_legal(start, len, size)) begin
            base = s - (s % win);
            return 32'(base + ((s - base + longint'(k) * step) % win));
        end
        return 32'(s + longint'(k) * step);
    endfunction

    function automatic bit oob(input logic [31:0] a);
        return (a >> 2) >= 32'(MEM_WORDS);
    endfunction

    task automatic do_write(input logic [IDW-1:0] id, input logic [31:0] addr, input int len,
                            input int size, input int burst, input logic [31:0] data[$],
                            input logic [3:0] strb, input int early, input int bhold,
                            output logic [1:0] resp);
        bit          err;
        int          t;
        logic [31:0] a;
        err = burst_bad(addr, len, size, burst);
        bus.awid = id; bus.awaddr = addr; bus.awlen = LENGTHW'(len);
        bus.awsize = SIZEW'(size); bus.awburst = 2'(burst); bus.awvalid = 1'b1;
        t = 0;
        while (!bus.awready && t < 100) begin tick(); t++; end
        chk("awready_wait", bus.awready, 1);
        tick();
        bus.awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            a = beat_addr(addr, len, size, burst, k);
            bus.wdata = data[k];
            bus.wstrb = strb;
            bus.wlast = (early >= 0) ? (k == early) : (k == len);
            bus.wvalid = 1'b1;
            if (bus.wlast != (k == len)) err = 1'b1;
            t = 0;
            while (!bus.wready && t < 100) begin tick(); t++; end
            chk("wready_wait", bus.wready, 1);
            tick();
            if (oob(a)) err = 1'b1;
            else for (int i = 0; i < 4; i++) if (strb[i]) model[a >> 2][i*8 +: 8] = data[k][i*8 +: 8];
        end
        bus.wvalid = 1'b0;
        bus.wlast = 1'b0;
        chk("bvalid_after_last", bus.bvalid, 1);
        chk("bid", bus.bid, id);
        chk("bresp", bus.bresp, err ? 2'b10 : 2'b00);
        resp = bus.bresp;
        for (int h = 0; h < bhold; h++) begin
            tick();
            chk("bvalid_hold", bus.bvalid, 1);
            chk("bid_hold", bus.bid, id);
            chk("bresp_hold", bus.bresp, err ? 2'b10 : 2'b00);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk("bvalid_clear", bus.bvalid, 0);
        chk("awready_back", bus.awready, 1);
    endtask

    task automatic do_read(input logic [IDW-1:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input bit toggle,
                           output logic [31:0] got[$], output logic [1:0] first_resp);
        int          t, k;
        bit          bad, rdy;
        logic [31:0] a;
        got = {};
        first_resp = 2'b11;
        bus.arid = id; bus.araddr = addr; bus.arlen = LENGTHW'(len);
        bus.arsize = SIZEW'(size); bus.arburst = 2'(burst); bus.arvalid = 1'b1;
        t = 0;
        while (!bus.arready && t < 100) begin tick(); t++; end
        chk("arready_wait", bus.arready, 1);
        tick();
        bus.arvalid = 1'b0;
        k = 0;
        t = 0;
        while (k <= len && t < 200) begin
            a   = beat_addr(addr, len, size, burst, k);
            bad = burst_bad(addr, len, size, burst) || oob(a);
            chk("rvalid", bus.rvalid, 1);
            chk("rdata", bus.rdata, oob(a) ? 32'h0 : model[a >> 2]);
            chk("rresp", bus.rresp, bad ? 2'b10 : 2'b00);
            chk("rlast", bus.rlast, (k == len));
            chk("rid", bus.rid, id);
            if (k == 0) first_resp = bus.rresp;
            rdy = toggle ? (t % 2 == 0) : 1'b1;
            bus.rready = rdy;
            if (rdy) got.push_back(bus.rdata);
            tick();
            t++;
            if (rdy) k++;
        end
        bus.rready = 1'b0;
        chk("beat_count", 64'(k), 64'(len + 1));
        chk("rvalid_clear", bus.rvalid, 0);
        chk("arready_back", bus.arready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dq[$];
        logic [31:0] got[$];
        logic [1:0]  resp;
        vec_t        tbl[9];
        logic [31:0] wrap_exp[4];
        int          len, size, burst;
        logic [31:0] addr;

        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
        bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        // Reset with AWVALID pending.
        rst = 1'b0;
        bus.awvalid = 1'b1;
        repeat (3) tick();
        chk("rst_awready", bus.awready, 0);
        chk("rst_wready", bus.wready, 0);
        chk("rst_bvalid", bus.bvalid, 0);
        chk("rst_arready", bus.arready, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_bid_bresp", {bus.bid, bus.bresp}, 0);
        chk("rst_rid_rdata", {bus.rid, bus.rdata}, 0);
        chk("rst_rresp_rlast", {bus.rresp, bus.rlast}, 0);
        rst = 1'b1;
        tick();
        chk("post_rst_awready", bus.awready, 1);
        chk("post_rst_arready", bus.arready, 1);
        bus.awvalid = 1'b0;

        // Fill the whole memory so the model is fully known.
        for (int b = 0; b < MEM_WORDS / 16; b++) begin
            dq = {};
            for (int k = 0; k < 16; k++) dq.push_back($urandom);
            do_write(1'b0, 32'(b * 64), 15, 2, 1, dq, 4'hF, -1, 0, resp);
        end

        // INCR write then readback of the same burst.
        dq = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
        do_write(1'b1, 32'h10, 3, 2, 1, dq, 4'hF, -1, 0, resp);
        chk("incr_bresp", resp, 2'b00);
        do_read(1'b1, 32'h10, 3, 2, 1, 1'b0, got, resp);
        for (int k = 0; k < 4; k++) chk($sformatf("incr_rdata%0d", k), got[k], 32'hA0 + 32'(k));

        // Backpressure on R and B.
        do_read(1'b0, 32'h40, 7, 2, 1, 1'b1, got, resp);
        dq = {32'h55};
        do_write(1'b1, 32'h80, 0, 2, 1, dq, 4'hF, -1, 5, resp);

        // WRAP read over words 0..3.
        dq = {32'h1, 32'h2, 32'h3, 32'h4};
        do_write(1'b0, 32'h0, 3, 2, 1, dq, 4'hF, -1, 0, resp);
        do_read(1'b0, 32'h08, 3, 2, 2, 1'b0, got, resp);
        wrap_exp = '{32'h3, 32'h4, 32'h1, 32'h2};
        for (int k = 0; k < 4; k++) chk($sformatf("wrap_rdata%0d", k), got[k], wrap_exp[k]);

        // Response table.
        tbl[0] = '{1'b0, 32'h10, 3, 2, 1, -1, 2'b00};
        tbl[1] = '{1'b0, 32'h40, 3, 2, 1,  1, 2'b10};
        tbl[2] = '{1'b1, 32'(MEM_WORDS * 4), 0, 2, 1, -1, 2'b10};
        tbl[3] = '{1'b1, 32'h10, 3, 3, 1, -1, 2'b10};
        tbl[4] = '{1'b1, 32'h00, 2, 2, 2, -1, 2'b10};
        tbl[5] = '{1'b1, 32'h10, 3, 2, 1, -1, 2'b00};
        tbl[6] = '{1'b0, 32'h00, 0, 2, 3, -1, 2'b10};
        tbl[7] = '{1'b1, 32'h04, 1, 2, 2, -1, 2'b00};
        tbl[8] = '{1'b1, 32'h02, 1, 2, 2, -1, 2'b10};
        for (int v = 0; v < 9; v++) begin
            if (tbl[v].is_rd) begin
                do_read(1'b0, tbl[v].addr, tbl[v].len, tbl[v].size, tbl[v].burst, 1'b0, got, resp);
            end else begin
                dq = {};
                for (int k = 0; k <= tbl[v].len; k++) dq.push_back(32'hA0 + 32'(k));
                do_write(1'b0, tbl[v].addr, tbl[v].len, tbl[v].size, tbl[v].burst, dq, 4'hF,
                         tbl[v].early, 0, resp);
            end
            chk($sformatf("table%0d_resp", v), resp, tbl[v].exp_resp);
        end

        // Same-cycle write beat and read load of word 5: read sees old data.
        dq = {32'h1234};
        do_write(1'b0, 32'h14, 0, 2, 1, dq, 4'hF, -1, 0, resp);
        bus.awaddr = 32'h14; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = 2'd1;
        bus.awvalid = 1'b1;
        chk("conc_awready", bus.awready, 1);
        tick();
        bus.awvalid = 1'b0;
        bus.wdata = 32'hBEEF; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = 32'h14; bus.arlen = '0; bus.arsize = 3'd2; bus.arburst = 2'd1;
        bus.arvalid = 1'b1;
        chk("conc_wready", bus.wready, 1);
        chk("conc_arready", bus.arready, 1);
        tick();
        bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.arvalid = 1'b0;
        chk("conc_rvalid", bus.rvalid, 1);
        chk("conc_rdata_old", bus.rdata, 32'h1234);
        chk("conc_bvalid", bus.bvalid, 1);
        model[5] = 32'hBEEF;
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        bus.bready = 1'b0; bus.rready = 1'b0;
        chk("conc_bvalid_clear", bus.bvalid, 0);
        chk("conc_rvalid_clear", bus.rvalid, 0);
        do_read(1'b0, 32'h14, 0, 2, 1, 1'b0, got, resp);
        chk("conc_rdata_new", got[0], 32'hBEEF);

        // Random traffic against the model.
        for (int n = 0; n < 40; n++) begin
            len   = $urandom_range(0, 15);
            size  = $urandom_range(0, 3);
            burst = $urandom_range(0, 3);
            addr  = 32'($urandom_range(0, (MEM_WORDS + 4) * 4 - 1));
            if ($urandom_range(0, 1) == 1) addr = addr & ~((32'd1 << size) - 32'd1);
            if ($urandom_range(0, 1) == 1) begin
                do_read(IDW'($urandom_range(0, 1)), addr, len, size, burst,
                        1'($urandom_range(0, 1)), got, resp);
            end else begin
                dq = {};
                for (int k = 0; k <= len; k++) dq.push_back($urandom);
                do_write(IDW'($urandom_range(0, 1)), addr, len, size, burst, dq,
                         4'($urandom_range(0, 15)), -1, $urandom_range(0, 2), resp);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
